// File: rtl/idct_scale_arb_if.sv
// Frame stream bus: valid/ready handshake with sop/eop framing and a complex sample.
interface idct_scale_arb_if #(
  parameter int wData = 42
);
  logic             valid;
  logic             ready;
  logic             sop;
  logic             eop;
  logic [wData-1:0] data_real;
  logic [wData-1:0] data_imag;

  modport master (output valid, sop, eop, data_real, data_imag, input ready);
  modport slave  (input valid, sop, eop, data_real, data_imag, output ready);
endinterface

// File: rtl/idct_scale_arb.sv
// Frame-level round-robin arbiter of two IDCT channels onto one scaling stage.
// Optional per-channel overflow counters are built when IDCT_SCALE_ARB_OVF_CNT_EN is defined.
module idct_scale_arb #(
  parameter int wData = 42,
  parameter int wCnt  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  idct_scale_arb_if.slave  sink0,
  idct_scale_arb_if.slave  sink1,
  idct_scale_arb_if.master src,
  output logic             src_chan,
  input  logic             ovf_in,
  input  logic             ovf_clr,
  output logic [wCnt-1:0]  ovf_cnt0,
  output logic [wCnt-1:0]  ovf_cnt1,
  output logic             drop_err
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   drop_nxt;
  logic   cand0, cand1, orphan0, orphan1;

  assign cand0   = sink0.valid & sink0.sop;
  assign cand1   = sink1.valid & sink1.sop;
  assign orphan0 = sink0.valid & ~sink0.sop;
  assign orphan1 = sink1.valid & ~sink1.sop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      drop_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      drop_err   <= drop_nxt;
    end
  end

  // Frames are only granted on a sop beat; anything else seen while idle is a frame tail and is dropped.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    drop_nxt       = drop_err;
    src.valid      = 1'b0;
    src.sop        = 1'b0;
    src.eop        = 1'b0;
    src.data_real  = {wData{1'b0}};
    src.data_imag  = {wData{1'b0}};
    src_chan       = 1'b0;
    sink0.ready    = 1'b0;
    sink1.ready    = 1'b0;
    case (state)
      IDLE: begin
        sink0.ready = orphan0;
        sink1.ready = orphan1;
        if (orphan0 | orphan1) drop_nxt = 1'b1;
        if (cand0 && (!cand1 || last_grant)) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (cand1) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0: begin
        src.valid     = sink0.valid;
        src.sop       = sink0.sop;
        src.eop       = sink0.eop;
        src.data_real = sink0.data_real;
        src.data_imag = sink0.data_imag;
        src_chan      = 1'b0;
        sink0.ready   = src.ready;
        if (sink0.valid && src.ready && sink0.eop) state_nxt = IDLE;
      end
      GRANT1: begin
        src.valid     = sink1.valid;
        src.sop       = sink1.sop;
        src.eop       = sink1.eop;
        src.data_real = sink1.data_real;
        src.data_imag = sink1.data_imag;
        src_chan      = 1'b1;
        sink1.ready   = src.ready;
        if (sink1.valid && src.ready && sink1.eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef IDCT_SCALE_ARB_OVF_CNT_EN
  logic chan_d1, xfer_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_d1 <= 1'b0;
      xfer_d1 <= 1'b0;
    end else begin
      chan_d1 <= src_chan;
      xfer_d1 <= src.valid & src.ready;
    end
  end

  // The overflow flag lags its beat by one cycle, so it is charged to the channel of the previous transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt0 <= {wCnt{1'b0}};
      ovf_cnt1 <= {wCnt{1'b0}};
    end else if (ovf_clr) begin
      ovf_cnt0 <= {wCnt{1'b0}};
      ovf_cnt1 <= {wCnt{1'b0}};
    end else if (ovf_in && xfer_d1) begin
      if (!chan_d1 && !(&ovf_cnt0)) ovf_cnt0 <= ovf_cnt0 + {{(wCnt-1){1'b0}}, 1'b1};
      if (chan_d1 && !(&ovf_cnt1))  ovf_cnt1 <= ovf_cnt1 + {{(wCnt-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_ovf;

  assign unused_ovf = ovf_in ^ ovf_clr;
  assign ovf_cnt0   = {wCnt{1'b0}};
  assign ovf_cnt1   = {wCnt{1'b0}};
`endif

endmodule

// File: tb/tb_idct_scale_arb.sv
// Self-checking bench for idct_scale_arb: directed frame scenarios plus randomized traffic against a frame-level model.
module tb_idct_scale_arb;
  localparam int W      = 12;
  localparam int C      = 3;
  localparam int CntMax = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         src_ready = 1'b0;
  logic         ovf_in = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         src_chan;
  logic         drop_err;
  logic [C-1:0] ovf_cnt0, ovf_cnt1;

  idct_scale_arb_if #(.wData(W)) sink0_bus ();
  idct_scale_arb_if #(.wData(W)) sink1_bus ();
  idct_scale_arb_if #(.wData(W)) src_bus ();

  assign src_bus.ready = src_ready;

  idct_scale_arb #(.wData(W), .wCnt(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sink0    (sink0_bus),
    .sink1    (sink1_bus),
    .src      (src_bus),
    .src_chan (src_chan),
    .ovf_in   (ovf_in),
    .ovf_clr  (ovf_clr),
    .ovf_cnt0 (ovf_cnt0),
    .ovf_cnt1 (ovf_cnt1),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         sop;
    bit         eop;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } beat_t;

  typedef struct {
    int cyc;
    int chan;
    bit sop;
    bit eop;
    int re;
  } log_t;

  beat_t q0[$];
  beat_t q1[$];
  log_t  xlog[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_mode = 1'b0;
  bit    held0 = 1'b0;
  bit    held1 = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic log_t logAt(input int i);
    log_t d;
    d = '{-1, -1, 1'b0, 1'b0, -1};
    if (i < xlog.size()) d = xlog[i];
    return d;
  endfunction

  // Behavioural reference: who owns the source, who won the last tie, and the overflow ledger.
  int m_owner = -1;
  int m_last = 1;
  int m_pchan = 0;
  bit m_drop = 1'b0;
  bit m_pxfer = 1'b0;
  int m_cnt[2] = '{0, 0};

  always @(negedge clk) begin : model
    bit           v[2], s[2], e[2], erdy[2];
    logic [W-1:0] r[2], im[2];
    bit           ev, xfer;
    int           ec;
    cyc++;
    v[0] = sink0_bus.valid; s[0] = sink0_bus.sop; e[0] = sink0_bus.eop;
    r[0] = sink0_bus.data_real; im[0] = sink0_bus.data_imag;
    v[1] = sink1_bus.valid; s[1] = sink1_bus.sop; e[1] = sink1_bus.eop;
    r[1] = sink1_bus.data_real; im[1] = sink1_bus.data_imag;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_drop = 1'b0; m_pxfer = 1'b0; m_pchan = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end
    if (m_owner < 0) begin
      ev = 1'b0; ec = 0;
      erdy[0] = v[0] && !s[0];
      erdy[1] = v[1] && !s[1];
    end else begin
      ec = m_owner; ev = v[ec];
      erdy[ec] = src_ready; erdy[1-ec] = 1'b0;
    end
    checkOutput("src_valid", src_bus.valid, ev);
    if (ev) begin
      checkOutput("src_chan", src_chan, ec);
      checkOutput("src_sop", src_bus.sop, s[ec]);
      checkOutput("src_eop", src_bus.eop, e[ec]);
      checkOutput("src_real", src_bus.data_real, r[ec]);
      checkOutput("src_imag", src_bus.data_imag, im[ec]);
    end
    checkOutput("sink0_ready", sink0_bus.ready, erdy[0]);
    checkOutput("sink1_ready", sink1_bus.ready, erdy[1]);
    checkOutput("drop_err", drop_err, m_drop);
    checkOutput("ovf_cnt0", ovf_cnt0, m_cnt[0]);
    checkOutput("ovf_cnt1", ovf_cnt1, m_cnt[1]);
    if (rst_n) begin
      xfer = ev && src_ready;
      if (xfer) xlog.push_back('{cyc, ec, s[ec], e[ec], int'(r[ec])});
      if (m_owner < 0) begin
        if (erdy[0] || erdy[1]) m_drop = 1'b1;
        if (v[0] && s[0] && v[1] && s[1]) m_owner = 1 - m_last;
        else if (v[0] && s[0]) m_owner = 0;
        else if (v[1] && s[1]) m_owner = 1;
        if (m_owner >= 0) m_last = m_owner;
      end else if (xfer && e[ec]) begin
        m_owner = -1;
      end
`ifdef IDCT_SCALE_ARB_OVF_CNT_EN
      if (ovf_clr) begin
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (ovf_in && m_pxfer && m_cnt[m_pchan] < CntMax) begin
        m_cnt[m_pchan]++;
      end
      m_pxfer = xfer;
      m_pchan = ec;
`endif
    end
  end

  task automatic pushBeat(input int ch, input bit sop, input bit eop, input int data);
    beat_t b;
    b.sop = sop; b.eop = eop;
    b.re = W'(data); b.im = W'(~data);
    if (ch == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic pushFrame(input int ch, input int len, input int base);
    for (int i = 0; i < len; i++) pushBeat(ch, i == 0, i == len - 1, base + i);
  endtask

  task automatic present();
    if (q0.size() > 0 && (held0 || !rand_mode || $urandom_range(0, 3) != 0)) begin
      sink0_bus.valid = 1'b1; sink0_bus.sop = q0[0].sop; sink0_bus.eop = q0[0].eop;
      sink0_bus.data_real = q0[0].re; sink0_bus.data_imag = q0[0].im;
    end else begin
      sink0_bus.valid = 1'b0; sink0_bus.sop = 1'b0; sink0_bus.eop = 1'b0;
      sink0_bus.data_real = '0; sink0_bus.data_imag = '0;
    end
    if (q1.size() > 0 && (held1 || !rand_mode || $urandom_range(0, 3) != 0)) begin
      sink1_bus.valid = 1'b1; sink1_bus.sop = q1[0].sop; sink1_bus.eop = q1[0].eop;
      sink1_bus.data_real = q1[0].re; sink1_bus.data_imag = q1[0].im;
    end else begin
      sink1_bus.valid = 1'b0; sink1_bus.sop = 1'b0; sink1_bus.eop = 1'b0;
      sink1_bus.data_real = '0; sink1_bus.data_imag = '0;
    end
    held0 = sink0_bus.valid;
    held1 = sink1_bus.valid;
  endtask

  task automatic refill();
    for (int ch = 0; ch < 2; ch++) begin
      if ((ch == 0 ? q0.size() : q1.size()) < 2) begin
        if ($urandom_range(0, 9) == 0) begin
          pushBeat(ch, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 4095));
        end else begin
          int len = $urandom_range(1, 5);
          int base = $urandom_range(0, 4095);
          for (int i = 0; i < len; i++)
            pushBeat(ch, i == 0 || $urandom_range(0, 7) == 0, i == len - 1, base + i);
        end
      end
    end
  endtask

  // One clock cycle: retire accepted beats, then present the next inputs just after the rising edge.
  task automatic applyStimulus();
    bit f0, f1;
    @(negedge clk);
    f0 = sink0_bus.valid & sink0_bus.ready;
    f1 = sink1_bus.valid & sink1_bus.ready;
    @(posedge clk);
    #1;
    if (f0) begin q0.delete(0); held0 = 1'b0; end
    if (f1) begin q1.delete(0); held1 = 1'b0; end
    if (rand_mode) begin
      src_ready = $urandom_range(0, 3) != 0;
      ovf_in    = $urandom_range(0, 2) == 0;
      ovf_clr   = $urandom_range(0, 63) == 0;
      refill();
    end
    present();
  endtask

  initial begin
    int exp_cnt;
    present();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_src_valid", src_bus.valid, 0);
    checkOutput("reset_drop_err", drop_err, 0);
    checkOutput("reset_ovf_cnt1", ovf_cnt1, 0);
    rst_n = 1'b1;
    applyStimulus();

    // Simultaneous frames on both channels alternate with one bubble between frames.
    src_ready = 1'b1;
    xlog.delete();
    pushFrame(0, 4, 'h000); pushFrame(0, 4, 'h010);
    pushFrame(1, 4, 'h100); pushFrame(1, 4, 'h110);
    present();
    repeat (22) applyStimulus();
    checkOutput("alt_count", xlog.size(), 16);
    checkOutput("alt_first_chan", logAt(0).chan, 0);
    checkOutput("alt_first_data", logAt(0).re, 'h000);
    checkOutput("alt_burst", logAt(3).cyc - logAt(0).cyc, 3);
    checkOutput("alt_bubble", logAt(4).cyc - logAt(3).cyc, 2);
    checkOutput("alt_second_chan", logAt(4).chan, 1);
    checkOutput("alt_second_data", logAt(4).re, 'h100);
    checkOutput("alt_third_chan", logAt(8).chan, 0);
    checkOutput("alt_third_data", logAt(8).re, 'h010);
    checkOutput("alt_fourth_chan", logAt(12).chan, 1);

    // Backpressure in the middle of a ch0 frame.
    xlog.delete();
    pushFrame(0, 4, 'h020); pushFrame(1, 2, 'h120);
    present();
    repeat (3) applyStimulus();
    src_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall_sink0_ready_%0d", i), sink0_bus.ready, 0);
      checkOutput($sformatf("stall_sink1_ready_%0d", i), sink1_bus.ready, 0);
      checkOutput($sformatf("stall_src_valid_%0d", i), src_bus.valid, 1);
      applyStimulus();
    end
    src_ready = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("stall_count", xlog.size(), 6);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall_chan_%0d", i), logAt(i).chan, 0);
      checkOutput($sformatf("stall_data_%0d", i), logAt(i).re, 'h020 + i);
    end
    checkOutput("stall_gap", logAt(2).cyc - logAt(1).cyc, 4);
    checkOutput("stall_then_ch1", logAt(4).chan, 1);

    // Single-beat ch1 frame followed by a ch0 frame.
    xlog.delete();
    pushFrame(1, 1, 'h130);
    present();
    repeat (3) applyStimulus();
    pushFrame(0, 4, 'h030);
    present();
    repeat (8) applyStimulus();
    checkOutput("single_count", xlog.size(), 5);
    checkOutput("single_chan", logAt(0).chan, 1);
    checkOutput("single_sop_eop", {logAt(0).sop, logAt(0).eop}, 2'b11);
    checkOutput("single_next_chan", logAt(1).chan, 0);
    checkOutput("single_next_sop", logAt(1).sop, 1);
    checkOutput("single_next_eop", logAt(4).eop, 1);

    // Orphan beats while idle are discarded and latch drop_err.
    checkOutput("orphan_pre_drop", drop_err, 0);
    xlog.delete();
    pushBeat(0, 1'b0, 1'b0, 'h0E0);
    pushBeat(0, 1'b0, 1'b1, 'h0E1);
    present();
    #1;
    checkOutput("orphan_ready", sink0_bus.ready, 1);
    checkOutput("orphan_src_valid", src_bus.valid, 0);
    repeat (3) applyStimulus();
    checkOutput("orphan_drop_err", drop_err, 1);
    checkOutput("orphan_no_xfer", xlog.size(), 0);
    checkOutput("orphan_consumed", q0.size(), 0);

    // Overflow attribution to ch1, then clear.
`ifdef IDCT_SCALE_ARB_OVF_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    pushFrame(1, 4, 'h140);
    present();
    repeat (2) applyStimulus();
    ovf_in = 1'b1;
    repeat (3) applyStimulus();
    ovf_in = 1'b0;
    checkOutput("ovf_cnt1_three", ovf_cnt1, exp_cnt);
    checkOutput("ovf_cnt0_zero", ovf_cnt0, 0);
    ovf_clr = 1'b1;
    applyStimulus();
    ovf_clr = 1'b0;
    checkOutput("ovf_cnt1_cleared", ovf_cnt1, 0);
    repeat (3) applyStimulus();

    // Reset in the middle of a ch0 frame.
    xlog.delete();
    pushFrame(0, 4, 'h050);
    present();
    repeat (3) applyStimulus();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_src_valid", src_bus.valid, 0);
    checkOutput("midrst_drop_err", drop_err, 0);
    applyStimulus();
    rst_n = 1'b1;
    repeat (2) applyStimulus();
    pushFrame(0, 4, 'h060);
    present();
    repeat (8) applyStimulus();
    checkOutput("midrst_drop_tail", drop_err, 1);
    checkOutput("midrst_count", xlog.size(), 6);
    checkOutput("midrst_new_data", logAt(2).re, 'h060);
    checkOutput("midrst_new_sop", logAt(2).sop, 1);
    checkOutput("midrst_new_eop", logAt(5).eop, 1);

    // Randomized traffic with backpressure, overflow pulses and occasional resets.
    rand_mode = 1'b1;
    repeat (4000) begin
      applyStimulus();
      if ($urandom_range(0, 799) == 0) begin
        #1;
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
